memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
Two-requester arbiter placed in front of the shared word-addressed Memory block. Port A is the controller/debug side (program load, readback); port B is the processor core. The block serialises requests onto one memory port with round-robin fairness and an A-side exclusive lock. It registers read data and returns a one-cycle response pulse to the granted requester.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
TIMEOUT_CYCLES, 16, watchdog limit in BUSY state (used only with ARBITER_TIMEOUT_EN)

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
a_read, a_write  in  1 each  port A strobes, held until a_response
a_address  in  ADDR_WIDTH  port A byte address
a_write_data  in  DATA_WIDTH  port A store data
a_read_data  out  DATA_WIDTH  port A registered load data
a_response  out  1  port A one-cycle completion pulse
a_lock  in  1  when high, port B is never granted
b_read, b_write, b_address, b_write_data, b_read_data, b_response  same as port A, for port B
mem_read, mem_write  out  1 each  strobes to Memory
mem_address  out  ADDR_WIDTH  address to Memory
mem_write_data  out  DATA_WIDTH  store data to Memory
mem_read_data  in  DATA_WIDTH  load data from Memory
mem_response  in  1  Memory completion; may be same-cycle or delayed
error  out  1  one-cycle pulse on timeout; constant 0 without ARBITER_TIMEOUT_EN

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, last_grant=B, all outputs 0 (read_data buses 0, responses 0, mem strobes 0, error 0).
- Request rule: a port is requesting when read|write is high. Requester holds strobes, address and data stable until its response pulse. If read and write are both high, the transaction is a write and read_data returns 0.
- FSM states: IDLE, BUSY_A, BUSY_B, RESP_A, RESP_B.
- IDLE: grant decided from registered request inputs.
  - Only A requesting -> BUSY_A.
  - Only B requesting and a_lock=0 -> BUSY_B.
  - Both requesting -> port not equal to last_grant. a_lock=1 forces A.
  - None requesting -> stay in IDLE.
  - last_grant updates on entry to BUSY_x.
- BUSY_x: mem_* driven combinationally from port x (mem strobes exactly mirror x's strobes, write precedence applied). Outputs are 0 in every other state.
  - On mem_response=1: capture mem_read_data (0 for writes) into x_read_data, go to RESP_x.
  - Otherwise stay in BUSY_x.
- RESP_x: x_response=1 for exactly this cycle. x_read_data holds its value until the next completion on that port. Requests are ignored this cycle. Next state is IDLE.
- Latency with single-cycle memory: request seen in cycle 0 (IDLE), memory access in cycle 1, response in cycle 2. The earliest new grant is cycle 3, giving a 3-cycle minimum per transaction.
- a_lock asserted mid-B transaction: the B transaction completes normally; B is then blocked from the next IDLE onward.
- A request dropped while in BUSY_x (protocol violation): the FSM continues to wait for mem_response. No recovery is guaranteed.
- Reset asserted mid-transaction: immediate return to IDLE, mem strobes low, no response pulse.

Optional Feature:
Macro ARBITER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY_x and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without mem_response: x_read_data=32'hDEADBEEF, go to RESP_x, and error pulses in the same cycle as x_response.
  - mem_response arriving on the cycle the counter reaches the limit wins (normal completion, no error).
- Not defined: no counter is built, BUSY waits indefinitely, error tied to 0.

Test Plan:
- A read alone at 0x10, memory word 0x12345678, single-cycle memory -> mem_read high in cycle 1 only; a_response in cycle 2 with a_read_data=0x12345678; b_response stays 0.
- A and B both write continuously, a_lock=0 -> grants A,B,A,B (A first after reset); each response spaced 3 cycles apart; memory contents match both writers.
- a_lock=1 with A and B both requesting for 4 transactions -> only A is granted. Drop a_lock -> B is granted at the next IDLE.
- Memory delays mem_response by 5 cycles on a B read -> stays in BUSY_B for 6 cycles; b_response one cycle after mem_response; A is held off throughout.
- A asserts read and write together at 0x20 with data 0xCAFEF00D -> memory written with 0xCAFEF00D; a_read_data=0; a_response pulses.
- ARBITER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, mem_response never asserted on an A read -> a_response and error pulse together with a_read_data=0xDEADBEEF; reset pulse mid-BUSY returns all outputs to 0.

Source files
------------

// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter with an A-side lock, in front of one memory port.
// Define ARBITER_TIMEOUT_EN to build the BUSY-state watchdog and error pulse.
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_read,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_write_data,
  output logic [DATA_WIDTH-1:0] a_read_data,
  output logic                  a_response,
  input  logic                  a_lock,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_write_data,
  output logic [DATA_WIDTH-1:0] b_read_data,
  output logic                  b_response,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  mem_response,
  output logic                  error
);

  typedef enum logic [2:0] {
    IDLE,
    BUSY_A,
    BUSY_B,
    RESP_A,
    RESP_B
  } state_t;

  state_t                state;
  state_t                next;
  logic                  last_b;
  logic                  last_b_nx;
  logic                  a_req;
  logic                  b_req;
  logic                  done;
  logic                  timeout;
  logic                  cap_write;
  logic [DATA_WIDTH-1:0] cap_data;

  assign a_req = a_read | a_write;
  assign b_req = b_read | b_write;
  assign done  = mem_response | timeout;

  assign a_response = (state == RESP_A);
  assign b_response = (state == RESP_B);

  // Writes (including read+write) return zero; a watchdog expiry returns a marker.
  assign cap_data = timeout   ? DATA_WIDTH'(32'hDEADBEEF) :
                    cap_write ? '0 : mem_read_data;

  always_comb begin
    next           = state;
    last_b_nx      = last_b;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    cap_write      = 1'b0;
    unique case (state)
      IDLE: begin
        if (a_req && (!b_req || a_lock || last_b)) begin
          next      = BUSY_A;
          last_b_nx = 1'b0;
        end else if (b_req && !a_lock) begin
          next      = BUSY_B;
          last_b_nx = 1'b1;
        end
      end
      BUSY_A: begin
        mem_read       = a_read & ~a_write;
        mem_write      = a_write;
        mem_address    = a_address;
        mem_write_data = a_write_data;
        cap_write      = a_write;
        if (done) next = RESP_A;
      end
      BUSY_B: begin
        mem_read       = b_read & ~b_write;
        mem_write      = b_write;
        mem_address    = b_address;
        mem_write_data = b_write_data;
        cap_write      = b_write;
        if (done) next = RESP_B;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      a_read_data <= '0;
      b_read_data <= '0;
    end else begin
      state  <= next;
      last_b <= last_b_nx;
      if (state == BUSY_A && done) a_read_data <= cap_data;
      if (state == BUSY_B && done) b_read_data <= cap_data;
    end
  end

`ifdef ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;
  logic          busy;
  logic          err_q;

  assign busy    = (state == BUSY_A) || (state == BUSY_B);
  // A same-cycle mem_response beats the watchdog.
  assign timeout = busy && !mem_response &&
                   (count == CW'(TIMEOUT_CYCLES - 1));
  assign error   = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      err_q <= 1'b0;
    end else begin
      count <= busy ? count + 1'b1 : '0;
      err_q <= timeout;
    end
  end
`else
  // No watchdog in this build: BUSY waits for mem_response indefinitely.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
  assign error   = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus random
// two-port traffic compared against a transaction-level reference model.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        a_read, a_write, a_lock, a_response;
  logic [31:0] a_address, a_write_data, a_read_data;
  logic        b_read, b_write, b_response;
  logic [31:0] b_address, b_write_data, b_read_data;
  logic        mem_read, mem_write, mem_response, error;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int          mem_delay = 0;
  int          mcnt = 0;
  bit          mem_hang = 1'b0;
  logic        pl_en = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .a_read(a_read),
    .a_write(a_write),
    .a_address(a_address),
    .a_write_data(a_write_data),
    .a_read_data(a_read_data),
    .a_response(a_response),
    .a_lock(a_lock),
    .b_read(b_read),
    .b_write(b_write),
    .b_address(b_address),
    .b_write_data(b_write_data),
    .b_read_data(b_read_data),
    .b_response(b_response),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .mem_response(mem_response),
    .error(error)
  );

  // Memory model: responds after mem_delay extra cycles.
  assign mem_response = (mem_read | mem_write) && !mem_hang &&
                        (mcnt == mem_delay);
  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if ((mem_read | mem_write) && !mem_response) mcnt <= mcnt + 1;
    else mcnt <= 0;
    if (mem_write && mem_response) mem[mem_address[9:2]] <= mem_write_data;
    if (pl_en) mem[pl_idx] <= pl_data;
  end

  task automatic drive_a(input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [31:0] dt);
    a_read = rd; a_write = wr; a_address = ad; a_write_data = dt;
  endtask

  task automatic drive_b(input logic rd, input logic wr,
                         input logic [31:0] ad, input logic [31:0] dt);
    b_read = rd; b_write = wr; b_address = ad; b_write_data = dt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    a_lock = 1'b0; mem_delay = 0; mem_hang = 1'b0; pl_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = 8'(idx); pl_data = d; ref_mem[idx] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_a(1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFF);
    drive_b(1, 0, 32'h0000_0040, 32'h1234_5678);
    a_lock = 1'b1;
    #2;
    vectors++;
    if ({mem_read, mem_write, a_response, b_response, error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_strobes got %b want 00000",
               {mem_read, mem_write, a_response, b_response, error});
    end
    vectors++;
    if (mem_address !== 32'd0 || mem_write_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mem_bus got %h/%h want 0/0", mem_address, mem_write_data);
    end
    vectors++;
    if (a_read_data !== 32'd0 || b_read_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_read_data got %h/%h want 0/0", a_read_data, b_read_data);
    end
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b0 || a_response !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_held got %b%b want 00", mem_read, a_response);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    poke(4, 32'h1234_5678);
    drive_a(1, 0, 32'h10, 0);
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'h10 ||
        a_response !== 1'b0 || b_response !== 1'b0) begin
      miscompares++;
      $display("FAIL single_access got rd%b wr%b addr%h resp%b want rd1 wr0 addr10 resp0",
               mem_read, mem_write, mem_address, a_response);
    end
    @(negedge clk);
    vectors++;
    if (a_response !== 1'b1 || a_read_data !== 32'h1234_5678 ||
        mem_read !== 1'b0 || b_response !== 1'b0) begin
      miscompares++;
      $display("FAIL single_resp got resp%b data%h rd%b b%b want resp1 data12345678 rd0 b0",
               a_response, a_read_data, mem_read, b_response);
    end
    drive_a(0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (a_response !== 1'b0 || b_response !== 1'b0 || a_read_data !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL single_after got a%b b%b data%h want a0 b0 data12345678",
               a_response, b_response, a_read_data);
    end
  endtask

  task automatic test_back_to_back();
    int na, nb, c, last_c, exp_port, got_port;
    logic [31:0] da, db;
    do_reset();
    na = 0; nb = 0; c = 0; last_c = -1; exp_port = 0;
    da = $urandom; db = $urandom;
    drive_a(0, 1, 32'h100, da);
    drive_b(0, 1, 32'h200, db);
    while (na + nb < 8 && c < 40) begin
      @(negedge clk);
      c++;
      if (a_response || b_response) begin
        got_port = a_response ? 0 : 1;
        vectors++;
        if (got_port != exp_port || (a_response && b_response)) begin
          miscompares++;
          $display("FAIL b2b_order got port%0d (a%b b%b) want port%0d",
                   got_port, a_response, b_response, exp_port);
        end
        vectors++;
        if (c - last_c != 3) begin
          miscompares++;
          $display("FAIL b2b_spacing got %0d cycles want 3", c - last_c);
        end
        last_c = c;
        if (a_response) begin
          ref_mem[64 + na] = da;
          na++;
          da = $urandom;
          if (na < 4) drive_a(0, 1, 32'(32'h100 + 4 * na), da);
          else drive_a(0, 0, 0, 0);
        end else begin
          ref_mem[128 + nb] = db;
          nb++;
          db = $urandom;
          if (nb < 4) drive_b(0, 1, 32'(32'h200 + 4 * nb), db);
          else drive_b(0, 0, 0, 0);
        end
        exp_port = 1 - exp_port;
      end
    end
    vectors++;
    if (na != 4 || nb != 4) begin
      miscompares++;
      $display("FAIL b2b_count got a%0d b%0d want a4 b4", na, nb);
    end
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[64 + i] !== ref_mem[64 + i] || mem[128 + i] !== ref_mem[128 + i]) begin
        miscompares++;
        $display("FAIL b2b_mem[%0d] got %h/%h want %h/%h", i,
                 mem[64 + i], mem[128 + i], ref_mem[64 + i], ref_mem[128 + i]);
      end
    end
  endtask

  task automatic test_lock();
    int na, c, last_c;
    bit got_b;
    do_reset();
    a_lock = 1'b1;
    drive_a(1, 0, 32'h0, 0);
    drive_b(1, 0, 32'h304, 0);
    na = 0; c = 0; last_c = 0; got_b = 1'b0;
    while (c < 40 && !got_b) begin
      @(negedge clk);
      c++;
      if (a_lock) begin
        vectors++;
        if (b_response !== 1'b0) begin
          miscompares++;
          $display("FAIL lock_blocks_b got b_response=%b want 0 (after %0d A)", b_response, na);
        end
      end
      if (b_response) begin
        got_b = 1'b1;
        vectors++;
        if (na != 4 || c - last_c != 3) begin
          miscompares++;
          $display("FAIL lock_release got %0d A grants, gap %0d want 4 A grants, gap 3",
                   na, c - last_c);
        end
      end else if (a_response) begin
        na++;
        last_c = c;
        if (na == 4) a_lock = 1'b0;
      end
    end
    vectors++;
    if (!got_b) begin
      miscompares++;
      $display("FAIL lock_b_timeout got no b_response want one within 40 cycles");
    end
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
  endtask

  task automatic test_delayed_response();
    logic [31:0] v;
    do_reset();
    v = $urandom;
    poke(16, v);
    mem_delay = 5;
    drive_b(1, 0, 32'h40, 0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) drive_a(1, 0, 32'h44, 0);
      vectors++;
      if (c <= 6) begin
        if (mem_read !== 1'b1 || mem_address !== 32'h40 ||
            a_response !== 1'b0 || b_response !== 1'b0) begin
          miscompares++;
          $display("FAIL delay_busy c%0d got rd%b addr%h a%b b%b want rd1 addr40 a0 b0",
                   c, mem_read, mem_address, a_response, b_response);
        end
      end else if (b_response !== 1'b1 || b_read_data !== v || a_response !== 1'b0) begin
        miscompares++;
        $display("FAIL delay_resp got b%b data%h a%b want b1 data%h a0",
                 b_response, b_read_data, a_response, v);
      end
    end
    drive_b(0, 0, 0, 0);
    mem_delay = 0;
    for (int c = 8; c <= 10; c++) begin
      @(negedge clk);
      vectors++;
      if (a_response !== (c == 10)) begin
        miscompares++;
        $display("FAIL delay_a_after c%0d got a_response=%b want %b", c, a_response, c == 10);
      end
    end
    drive_a(0, 0, 0, 0);
  endtask

  task automatic test_read_write_both();
    logic [31:0] v;
    do_reset();
    v = $urandom | 32'd1;
    poke(9, v);
    drive_a(1, 0, 32'h24, 0);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (a_response !== 1'b1 || a_read_data !== v) begin
      miscompares++;
      $display("FAIL rw_preload got resp%b data%h want resp1 data%h", a_response, a_read_data, v);
    end
    drive_a(1, 1, 32'h20, 32'hCAFE_F00D);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'h20 ||
        mem_write_data !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL rw_strobes got rd%b wr%b addr%h data%h want rd0 wr1 addr20 dataCAFEF00D",
               mem_read, mem_write, mem_address, mem_write_data);
    end
    @(negedge clk);
    vectors++;
    if (a_response !== 1'b1 || a_read_data !== 32'd0) begin
      miscompares++;
      $display("FAIL rw_resp got resp%b data%h want resp1 data0", a_response, a_read_data);
    end
    drive_a(0, 0, 0, 0);
    @(negedge clk);
    vectors++;
    if (mem[8] !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL rw_mem got %h want CAFEF00D", mem[8]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mem_delay = 3;
    drive_a(1, 0, 32'h10, 0);
    @(negedge clk);
    vectors++;
    if (mem_read !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy got mem_read=%b want 1", mem_read);
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({mem_read, mem_write, a_response, b_response, error} !== 5'b0 ||
        mem_address !== 32'd0 || a_read_data !== 32'd0) begin
      miscompares++;
      $display("FAIL mid_reset got strobes %b addr%h data%h want 00000 0 0",
               {mem_read, mem_write, a_response, b_response, error}, mem_address, a_read_data);
    end
    drive_a(0, 0, 0, 0);
    mem_delay = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++;
      if (a_response !== 1'b0 || mem_read !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_no_resp c%0d got resp%b rd%b want 0 0", c, a_response, mem_read);
      end
    end
  endtask

  task automatic test_random();
    int m_free, m_cur, m_last, m_resp, w, ia, ib;
    logic [31:0] m_data, wa, wb;
    logic [1:0] op_a, op_b;
    bit pa, pb, exp_a, exp_b, ca, cb;
    do_reset();
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    m_free = 0; m_cur = -1; m_last = 1; m_resp = 0; m_data = 0;
    pa = 1'b0; pb = 1'b0; ia = 0; ib = 0; wa = 0; wb = 0; op_a = 0; op_b = 0;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) @(negedge clk);
      exp_a = (m_cur == 0 && c == m_resp);
      exp_b = (m_cur == 1 && c == m_resp);
      vectors++;
      if (a_response !== exp_a || b_response !== exp_b || error !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_resp c%0d got a%b b%b err%b want a%b b%b err0",
                 c, a_response, b_response, error, exp_a, exp_b);
      end
      if (exp_a) begin
        vectors++;
        if (a_read_data !== m_data) begin
          miscompares++;
          $display("FAIL rand_a_data c%0d got %h want %h", c, a_read_data, m_data);
        end
        pa = 1'b0;
      end
      if (exp_b) begin
        vectors++;
        if (b_read_data !== m_data) begin
          miscompares++;
          $display("FAIL rand_b_data c%0d got %h want %h", c, b_read_data, m_data);
        end
        pb = 1'b0;
      end
      if (exp_a || exp_b) begin
        m_cur = -1;
        m_free = c + 1;
      end
      if (c < 580) begin
        if ($urandom_range(0, 15) == 0) a_lock = ~a_lock;
      end else begin
        a_lock = 1'b0;
      end
      if (!pa) begin
        if (c < 580 && $urandom_range(0, 2) == 0) begin
          pa = 1'b1;
          op_a = 2'($urandom_range(1, 3));
          ia = int'($urandom_range(0, 15));
          wa = $urandom;
          drive_a(op_a[1], op_a[0], 32'(ia * 4), wa);
        end else drive_a(0, 0, 0, 0);
      end
      if (!pb) begin
        if (c < 580 && $urandom_range(0, 2) == 0) begin
          pb = 1'b1;
          op_b = 2'($urandom_range(1, 3));
          ib = int'($urandom_range(0, 15));
          wb = $urandom;
          drive_b(op_b[1], op_b[0], 32'(ib * 4), wb);
        end else drive_b(0, 0, 0, 0);
      end
      if (m_cur < 0 && c >= m_free) begin
        ca = pa;
        cb = pb && !a_lock;
        w = -1;
        if (ca && cb) w = 1 - m_last;
        else if (ca) w = 0;
        else if (cb) w = 1;
        if (w >= 0) begin
          mem_delay = int'($urandom_range(0, 3));
          m_cur = w;
          m_last = w;
          m_resp = c + 2 + mem_delay;
          if (w == 0) begin
            m_data = op_a[0] ? 32'd0 : ref_mem[ia];
            if (op_a[0]) ref_mem[ia] = wa;
          end else begin
            m_data = op_b[0] ? 32'd0 : ref_mem[ib];
            if (op_b[0]) ref_mem[ib] = wb;
          end
        end
      end
    end
    vectors++;
    if (pa || pb) begin
      miscompares++;
      $display("FAIL rand_drain got pending a%b b%b want 0 0", pa, pb);
    end
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (mem[i] !== ref_mem[i]) begin
        miscompares++;
        $display("FAIL rand_mem[%0d] got %h want %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

`ifdef ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    bit got;
    do_reset();
    mem_hang = 1'b1;
    drive_a(1, 0, 32'h10, 0);
    got = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(negedge clk);
      vectors++;
      if (error !== a_response) begin
        miscompares++;
        $display("FAIL timeout_error_align c%0d got err%b resp%b want equal", c, error, a_response);
      end
      if (a_response) begin
        got = 1'b1;
        vectors++;
        if (c != 17 || a_read_data !== 32'hDEAD_BEEF || error !== 1'b1) begin
          miscompares++;
          $display("FAIL timeout_resp got c%0d data%h err%b want c17 dataDEADBEEF err1",
                   c, a_read_data, error);
        end
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL timeout_none got no a_response want one within 40 cycles");
    end
    drive_a(0, 0, 0, 0);
    mem_hang = 1'b0;
  endtask
`endif

  initial begin
    a_lock = 1'b0;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_lock();
    test_delayed_response();
    test_read_write_both();
    test_reset_mid();
    test_random();
`ifdef ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
